// File: rtl/uart_tx.sv
// -----------------------------------------------------------------------------
// uart_tx
//
// Serial UART transmitter. A word presented with Data_valid while idle is sent
// as: start bit (0), Data_width data bits LSB first, optional parity bit, one
// stop bit (1). Every bit is held for N clocks, where N is the prescale value
// captured when the word was accepted (0 is treated as 1), so this side runs
// on the same oversampling clock and prescale setting as its receiving peer.
//
// Ports
//   CLK         in   clock, everything on the rising edge
//   RST         in   synchronous active-low reset
//   P_DATA      in   word to transmit
//   Data_valid  in   request strobe, only honoured while busy = 0
//   prescale    in   clocks per bit (1..63, 0 behaves as 1)
//   PAR_EN      in   1 = append a parity bit after the data
//   PAR_TYP     in   0 = even parity, 1 = odd parity
//   TX_OUT      out  serial line, idles high (registered)
//   busy        out  high from the first start-bit cycle to the last
//                    stop-bit cycle (registered)
// -----------------------------------------------------------------------------
module uart_tx #(
    parameter int Data_width = 8
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [Data_width-1:0] P_DATA,
    input  logic                  Data_valid,
    input  logic [5:0]            prescale,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    output logic                  TX_OUT,
    output logic                  busy
);

    localparam int BCW = (Data_width > 1) ? $clog2(Data_width) : 1;
    localparam logic [BCW-1:0] LAST_BIT = BCW'(Data_width - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_e;

    state_e                state_q,    state_d;
    logic [Data_width-1:0] shift_q,    shift_d;
    logic [5:0]            presc_q,    presc_d;
    logic                  par_en_q,   par_en_d;
    logic                  par_bit_q,  par_bit_d;
    logic [5:0]            edge_cnt_q, edge_cnt_d;
    logic [BCW-1:0]        bit_cnt_q,  bit_cnt_d;
    logic                  tx_q,       tx_d;
    logic                  busy_q,     busy_d;

    logic [5:0]            n_last_s;
    logic                  bit_done_s;

    // Last edge-counter value of a bit period; a captured prescale of 0
    // behaves like 1, so both give a one-cycle bit.
    assign n_last_s   = (presc_q == 6'd0) ? 6'd0 : (presc_q - 6'd1);
    assign bit_done_s = (edge_cnt_q == n_last_s);

    // Next-state and datapath update: frame sequencing, bit timing, shifting.
    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        presc_d    = presc_q;
        par_en_d   = par_en_q;
        par_bit_d  = par_bit_q;
        edge_cnt_d = edge_cnt_q;
        bit_cnt_d  = bit_cnt_q;

        case (state_q)
            IDLE: begin
                edge_cnt_d = 6'd0;
                bit_cnt_d  = '0;
                if (Data_valid) begin
                    // Everything the frame depends on is frozen here, so
                    // later input changes cannot disturb the frame.
                    shift_d   = P_DATA;
                    presc_d   = prescale;
                    par_en_d  = PAR_EN;
                    par_bit_d = (^P_DATA) ^ PAR_TYP;
                    state_d   = START;
                end else begin
                    state_d   = IDLE;
                end
            end
            START: begin
                if (bit_done_s) begin
                    edge_cnt_d = 6'd0;
                    state_d    = DATA;
                end else begin
                    edge_cnt_d = edge_cnt_q + 6'd1;
                end
            end
            DATA: begin
                if (bit_done_s) begin
                    edge_cnt_d = 6'd0;
                    shift_d    = shift_q >> 1;
                    if (bit_cnt_q == LAST_BIT) begin
                        bit_cnt_d = '0;
                        state_d   = par_en_q ? PARITY : STOP;
                    end else begin
                        bit_cnt_d = bit_cnt_q + BCW'(1);
                    end
                end else begin
                    edge_cnt_d = edge_cnt_q + 6'd1;
                end
            end
            PARITY: begin
                if (bit_done_s) begin
                    edge_cnt_d = 6'd0;
                    state_d    = STOP;
                end else begin
                    edge_cnt_d = edge_cnt_q + 6'd1;
                end
            end
            STOP: begin
                if (bit_done_s) begin
                    edge_cnt_d = 6'd0;
                    state_d    = IDLE;
                end else begin
                    edge_cnt_d = edge_cnt_q + 6'd1;
                end
            end
            default: begin
                state_d    = IDLE;
                edge_cnt_d = 6'd0;
                bit_cnt_d  = '0;
            end
        endcase
    end

    // Output decode from the upcoming state, so the registered line and busy
    // flag change on the same edge as the state itself.
    always_comb begin
        tx_d   = 1'b1;
        busy_d = 1'b0;
        case (state_d)
            IDLE: begin
                tx_d   = 1'b1;
                busy_d = 1'b0;
            end
            START: begin
                tx_d   = 1'b0;
                busy_d = 1'b1;
            end
            DATA: begin
                tx_d   = shift_d[0];
                busy_d = 1'b1;
            end
            PARITY: begin
                tx_d   = par_bit_d;
                busy_d = 1'b1;
            end
            STOP: begin
                tx_d   = 1'b1;
                busy_d = 1'b1;
            end
            default: begin
                tx_d   = 1'b1;
                busy_d = 1'b0;
            end
        endcase
    end

    // State, datapath and output registers with synchronous active-low reset.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            state_q    <= IDLE;
            shift_q    <= '0;
            presc_q    <= 6'd0;
            par_en_q   <= 1'b0;
            par_bit_q  <= 1'b0;
            edge_cnt_q <= 6'd0;
            bit_cnt_q  <= '0;
            tx_q       <= 1'b1;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            presc_q    <= presc_d;
            par_en_q   <= par_en_d;
            par_bit_q  <= par_bit_d;
            edge_cnt_q <= edge_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            tx_q       <= tx_d;
            busy_q     <= busy_d;
        end
    end

    assign TX_OUT = tx_q;
    assign busy   = busy_q;

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: directed scenarios plus randomized frames, every cycle of
// each frame compared against a line waveform built from the frame format.
module tb_uart_tx;

    localparam int DW = 8;

    logic          CLK = 1'b0;
    logic          RST;
    logic [DW-1:0] P_DATA;
    logic          Data_valid;
    logic [5:0]    prescale;
    logic          PAR_EN;
    logic          PAR_TYP;
    logic          TX_OUT;
    logic          busy;

    int errors = 0;
    int checks = 0;

    // Expected line level for every busy cycle of the current frame.
    logic exp_q[$];

    uart_tx #(.Data_width(DW)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .P_DATA     (P_DATA),
        .Data_valid (Data_valid),
        .prescale   (prescale),
        .PAR_EN     (PAR_EN),
        .PAR_TYP    (PAR_TYP),
        .TX_OUT     (TX_OUT),
        .busy       (busy)
    );

    always #5 CLK = ~CLK;

    // Advance one clock; sampling and driving happen 1 time unit after the edge.
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic check(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // Reference: the frame is start(0), data LSB first, optional parity
    // (XOR of data, inverted for odd), stop(1); each bit lasts N clocks.
    task automatic build_frame(input logic [DW-1:0] d, input logic [5:0] ps,
                               input logic pen, input logic ptyp);
        logic bits[$];
        int   n;
        n = (ps == 6'd0) ? 1 : int'(ps);
        bits.push_back(1'b0);
        for (int b = 0; b < DW; b++) bits.push_back(d[b]);
        if (pen) bits.push_back((^d) ^ ptyp);
        bits.push_back(1'b1);
        exp_q.delete();
        foreach (bits[k])
            for (int r = 0; r < n; r++) exp_q.push_back(bits[k]);
    endtask

    // Present a word in an idle cycle, let it be accepted on the next edge,
    // then compare every frame cycle. Inputs during the frame per mode:
    //   0: Data_valid low           1: Data_valid high, other inputs random
    //   2: single 0x3C pulse mid    3: everything random
    // Returns in the idle cycle after the frame with Data_valid low, or early
    // right after checking cycle abort_at.
    task automatic run_frame(input string tag, input logic [DW-1:0] d,
                             input logic [5:0] ps, input logic pen,
                             input logic ptyp, input int mode, input int abort_at);
        int len;
        build_frame(d, ps, pen, ptyp);
        len        = exp_q.size();
        P_DATA     = d;
        prescale   = ps;
        PAR_EN     = pen;
        PAR_TYP    = ptyp;
        Data_valid = 1'b1;
        tick();
        for (int i = 0; i < len; i++) begin
            check($sformatf("%s tx[%0d]", tag, i), TX_OUT, exp_q[i]);
            check($sformatf("%s busy[%0d]", tag, i), busy, 1'b1);
            if (i == abort_at) return;
            case (mode)
                0: Data_valid = 1'b0;
                1: begin
                    Data_valid = 1'b1;
                    P_DATA     = DW'($urandom);
                    prescale   = 6'($urandom_range(63));
                    PAR_EN     = 1'($urandom_range(1));
                    PAR_TYP    = 1'($urandom_range(1));
                end
                2: begin
                    Data_valid = (i == len / 2) ? 1'b1 : 1'b0;
                    P_DATA     = 8'h3C;
                end
                default: begin
                    Data_valid = 1'($urandom_range(1));
                    P_DATA     = DW'($urandom);
                    prescale   = 6'($urandom_range(63));
                    PAR_EN     = 1'($urandom_range(1));
                    PAR_TYP    = 1'($urandom_range(1));
                end
            endcase
            tick();
        end
        Data_valid = 1'b0;
        check({tag, " idle tx"}, TX_OUT, 1'b1);
        check({tag, " idle busy"}, busy, 1'b0);
    endtask

    initial begin
        // Reset held with a pending request: the line must stay idle.
        RST        = 1'b0;
        Data_valid = 1'b1;
        P_DATA     = 8'h5A;
        prescale   = 6'd2;
        PAR_EN     = 1'b1;
        PAR_TYP    = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("reset tx[%0d]", i), TX_OUT, 1'b1);
            check($sformatf("reset busy[%0d]", i), busy, 1'b0);
        end
        RST = 1'b1;

        // First edge with RST high accepts; busy for exactly 88 cycles.
        run_frame("even", 8'hA5, 6'd8, 1'b1, 1'b0, 0, -1);
        tick();
        run_frame("odd", 8'hA5, 6'd8, 1'b1, 1'b1, 0, -1);
        tick();
        run_frame("nopar", 8'hA5, 6'd8, 1'b0, 1'b0, 0, -1);
        tick();

        // Back-to-back with Data_valid held and inputs changing mid-frame.
        run_frame("b2b0", 8'h00, 6'd16, 1'b1, 1'b0, 1, -1);
        run_frame("b2b1", 8'hFF, 6'd16, 1'b1, 1'b0, 1, -1);
        tick();
        check("b2b stop tx", TX_OUT, 1'b1);
        check("b2b stop busy", busy, 1'b0);

        // Request while busy is dropped, not queued.
        run_frame("drop", 8'hC3, 6'd3, 1'b1, 1'b1, 2, -1);
        tick();
        check("drop no-frame tx", TX_OUT, 1'b1);
        check("drop no-frame busy", busy, 1'b0);

        // Reset during data bit 3 (cycles 16..19 at prescale 4).
        run_frame("abort", 8'hA5, 6'd4, 1'b1, 1'b0, 0, 17);
        RST        = 1'b0;
        Data_valid = 1'b0;
        tick();
        check("abort tx", TX_OUT, 1'b1);
        check("abort busy", busy, 1'b0);
        RST = 1'b1;
        run_frame("after-abort", 8'h55, 6'd1, 1'b1, 1'b0, 0, -1);
        tick();

        // Prescale extremes.
        run_frame("ps0", 8'h96, 6'd0, 1'b1, 1'b1, 0, -1);
        tick();
        run_frame("ps63", 8'h3B, 6'd63, 1'b0, 1'b1, 3, -1);
        tick();

        // Randomized frames with random input noise during each frame.
        for (int f = 0; f < 24; f++) begin
            run_frame($sformatf("rand%0d", f), DW'($urandom),
                      6'($urandom_range(12)), 1'($urandom_range(1)),
                      1'($urandom_range(1)), 3, -1);
            if ($urandom_range(1) == 1) tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
